// File: rtl/frame_stamper_if.sv
// rtl/frame_stamper_if.sv - frame stamper request, BRAM write and transmitter handshake bundle
//
// Signals:
//   trigger      frame request
//   payload      32-bit payload word, captured on accepted trigger
//   tx_busy      transmitter busy
//   bram_wr_en   BRAM write enable
//   bram_wr_addr BRAM byte write address
//   bram_wr_data BRAM write data
//   start        transmitter start pulse
//   busy         stamper not idle
//   done         frame-complete pulse
//   timeout      sticky transmitter no-response flag
//   drop_cnt     saturating count of ignored triggers
// Modports: master = stamper side, slave = environment side.

interface frame_stamper_if;
    logic        trigger;
    logic [31:0] payload;
    logic        tx_busy;
    logic        bram_wr_en;
    logic [9:0]  bram_wr_addr;
    logic [7:0]  bram_wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  drop_cnt;

    modport master (
        input  trigger, payload, tx_busy,
        output bram_wr_en, bram_wr_addr, bram_wr_data,
        output start, busy, done, timeout, drop_cnt
    );

    modport slave (
        output trigger, payload, tx_busy,
        input  bram_wr_en, bram_wr_addr, bram_wr_data,
        input  start, busy, done, timeout, drop_cnt
    );
endinterface

// File: rtl/frame_stamper.sv
// rtl/frame_stamper.sv - patches IPv4 ID, header checksum and payload word into the TX frame template, then starts the transmitter
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   clk_en  clock-enable strobe; every register advances only when high
//   fs      frame_stamper_if.master (trigger/payload/tx_busy in; BRAM write port, start, busy, done, timeout, drop_cnt out)
// Optional feature macro: FRAME_STAMPER_AUTO_TRIG_EN
//   defined   - internal 21-bit period counter adds a trigger on each wrap; payload comes from an internal frame counter
//   undefined - only fs.trigger starts frames and fs.payload is used

module frame_stamper #(
    parameter logic [9:0]  IPID_ADDR    = 10'h01A,
    parameter logic [9:0]  CSUM_ADDR    = 10'h020,
    parameter logic [9:0]  PAYLOAD_ADDR = 10'h038,
    parameter logic [15:0] CSUM_BASE    = 16'hB861,
    parameter int          BUSY_TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst_n,
    input logic             clk_en,
    frame_stamper_if.master fs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WRITE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    // Terminal value of the wait counter: WAIT_HI gives up after BUSY_TIMEOUT enabled cycles.
    localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

    state_t      state;
    logic [15:0] ip_id;
    logic [15:0] csum;
    logic [31:0] payload_q;
    logic [2:0]  k;
    logic [7:0]  to_cnt;

    logic [16:0] csum_sum;
    logic [15:0] csum_fold;
    logic [2:0]  nxt_idx;
    logic [9:0]  nxt_addr;
    logic [7:0]  nxt_data;
    logic        trig_in;
    logic [31:0] payload_src;
    logic        accept;

`ifdef FRAME_STAMPER_AUTO_TRIG_EN
    logic [20:0] period_cnt;
    logic [31:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (clk_en) begin
            period_cnt <= period_cnt + 21'd1;
        end
    end

    // The auto trigger fires on the cycle the period counter rolls over.
    assign trig_in     = fs.trigger | (period_cnt == '1);
    assign payload_src = frame_cnt;
`else
    assign trig_in     = fs.trigger;
    assign payload_src = fs.payload;
`endif

    assign accept = trig_in && (state == S_IDLE) && !fs.tx_busy;

    // Ones-complement add of the ID into the precomputed static sum, with end-around carry.
    assign csum_sum  = {1'b0, CSUM_BASE} + {1'b0, ip_id};
    assign csum_fold = csum_sum[15:0] + {15'd0, csum_sum[16]};

    // Address/data for the byte following the one currently on the write port.
    assign nxt_idx = k + 3'd1;

    always_comb begin
        nxt_addr = IPID_ADDR;
        nxt_data = ip_id[15:8];
        case (nxt_idx)
            3'd1: begin nxt_addr = IPID_ADDR + 10'd1;    nxt_data = ip_id[7:0];       end
            3'd2: begin nxt_addr = CSUM_ADDR;            nxt_data = csum[15:8];       end
            3'd3: begin nxt_addr = CSUM_ADDR + 10'd1;    nxt_data = csum[7:0];        end
            3'd4: begin nxt_addr = PAYLOAD_ADDR;         nxt_data = payload_q[31:24]; end
            3'd5: begin nxt_addr = PAYLOAD_ADDR + 10'd1; nxt_data = payload_q[23:16]; end
            3'd6: begin nxt_addr = PAYLOAD_ADDR + 10'd2; nxt_data = payload_q[15:8];  end
            3'd7: begin nxt_addr = PAYLOAD_ADDR + 10'd3; nxt_data = payload_q[7:0];   end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            ip_id           <= '0;
            csum            <= '0;
            payload_q       <= '0;
            k               <= '0;
            to_cnt          <= '0;
            fs.bram_wr_en   <= 1'b0;
            fs.bram_wr_addr <= '0;
            fs.bram_wr_data <= '0;
            fs.start        <= 1'b0;
            fs.busy         <= 1'b0;
            fs.done         <= 1'b0;
            fs.timeout      <= 1'b0;
            fs.drop_cnt     <= '0;
`ifdef FRAME_STAMPER_AUTO_TRIG_EN
            frame_cnt       <= '0;
`endif
        end else if (clk_en) begin
            fs.done <= 1'b0;

            if (trig_in && !accept && (fs.drop_cnt != 8'hFF)) begin
                fs.drop_cnt <= fs.drop_cnt + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        payload_q <= payload_src;
                        fs.busy   <= 1'b1;
                        state     <= S_CALC;
`ifdef FRAME_STAMPER_AUTO_TRIG_EN
                        frame_cnt <= frame_cnt + 32'd1;
`endif
                    end
                end

                // First byte only needs ip_id, so it goes out together with the checksum register load.
                S_CALC: begin
                    csum            <= ~csum_fold;
                    k               <= 3'd0;
                    fs.bram_wr_en   <= 1'b1;
                    fs.bram_wr_addr <= IPID_ADDR;
                    fs.bram_wr_data <= ip_id[15:8];
                    state           <= S_WRITE;
                end

                S_WRITE: begin
                    if (k == 3'd7) begin
                        fs.bram_wr_en <= 1'b0;
                        state         <= S_START;
                    end else begin
                        k               <= nxt_idx;
                        fs.bram_wr_addr <= nxt_addr;
                        fs.bram_wr_data <= nxt_data;
                    end
                end

                // One idle cycle after the last write, then a single-cycle start pulse.
                S_START: begin
                    if (!fs.start) begin
                        fs.start <= 1'b1;
                    end else begin
                        fs.start <= 1'b0;
                        to_cnt   <= '0;
                        state    <= S_WAIT_HI;
                    end
                end

                S_WAIT_HI: begin
                    if (fs.tx_busy) begin
                        state <= S_WAIT_LO;
                    end else if (to_cnt == TO_LAST) begin
                        fs.timeout <= 1'b1;
                        ip_id      <= ip_id + 16'd1;
                        fs.busy    <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end

                S_WAIT_LO: begin
                    if (!fs.tx_busy) begin
                        fs.done <= 1'b1;
                        ip_id   <= ip_id + 16'd1;
                        fs.busy <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
